// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared core/request/response types and the arbiter FSM state enum
package io_bus_arbiter_pkg;
  localparam int NUM_CORES = 4;
  typedef logic [3:0] core_id_t;
  typedef logic [1:0] thread_idx_t;
  typedef logic [31:0] scalar_t;
  typedef struct packed {
    logic store;
    thread_idx_t thread_idx;
    scalar_t address;
    scalar_t value;
  } ioreq_packet_t;
  typedef struct packed {
    core_id_t core;
    thread_idx_t thread_idx;
    scalar_t read_value;
  } iorsp_packet_t;
  typedef enum logic [1:0] {IDLE, BUS, RESP} io_arb_state_t;
endpackage

// File: rtl/io_bus_interface.sv
// io_bus_interface: non-cached peripheral bus; master drives strobes/address/write_data, slave returns read_data one cycle after read_en
interface io_bus_interface;
  import io_bus_arbiter_pkg::*;
  logic write_en;
  logic read_en;
  scalar_t address;
  scalar_t write_data;
  scalar_t read_data;
  modport master(output write_en, read_en, address, write_data, input read_data);
  modport slave(input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant from request bitmap (ports clk, reset_n, request, update_en, grant); pointer advances past the winner on update_en
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_en,
  output logic [NUM_REQUESTERS-1:0] grant
);
  localparam int PW = NUM_REQUESTERS > 1 ? $clog2(NUM_REQUESTERS) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  logic hit;
  int sel;
  always_comb begin
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (!hit && request[i] && i >= int'(ptr_q)) begin
        hit = 1'b1;
        sel = i;
      end
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (!hit && request[i]) begin
        hit = 1'b1;
        sel = i;
      end
    for (int i = 0; i < NUM_REQUESTERS; i++) grant[i] = hit && sel == i;
    ptr_d = (update_en && hit) ? (sel == NUM_REQUESTERS - 1 ? '0 : PW'(sel + 1)) : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter serialising per-core IO requests onto one peripheral bus (ports clk, reset_n, ioreq_valid/ioreq in, ioreq_ack/iorsp_valid/iorsp out, io_bus master)
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] ioreq_valid,
  input  ioreq_packet_t             ioreq [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] ioreq_ack,
  output logic                      iorsp_valid,
  output iorsp_packet_t             iorsp,
  io_bus_interface.master           io_bus
);
  logic [NUM_REQUESTERS-1:0] grant;
  logic grant_en;
  io_arb_state_t state_q, state_d;
  ioreq_packet_t pkt_q, pkt_d;
  core_id_t core_q, core_d;
  rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_rr (
    .clk(clk),
    .reset_n(reset_n),
    .request(ioreq_valid),
    .update_en(grant_en),
    .grant(grant)
  );
  always_comb begin
    grant_en = reset_n && state_q == IDLE && |ioreq_valid;
    ioreq_ack = grant_en ? grant : '0;
    pkt_d = pkt_q;
    core_d = core_q;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (grant_en && grant[i]) begin
        pkt_d = ioreq[i];
        core_d = core_id_t'(i);
      end
    state_d = state_q == IDLE ? (grant_en ? BUS : IDLE) : state_q == BUS ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pkt_q <= '0;
      core_q <= '0;
    end else begin
      state_q <= state_d;
      pkt_q <= pkt_d;
      core_q <= core_d;
    end
  assign io_bus.write_en = state_q == BUS && pkt_q.store;
  assign io_bus.read_en = state_q == BUS && !pkt_q.store;
  assign io_bus.address = pkt_q.address;
  assign io_bus.write_data = pkt_q.value;
  assign iorsp_valid = state_q == RESP;
  assign iorsp.core = core_q;
  assign iorsp.thread_idx = pkt_q.thread_idx;
  assign iorsp.read_value = (state_q == RESP && !pkt_q.store) ? io_bus.read_data : '0;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: table-driven and directed checks of grant order, bus strobes, responses and reset behaviour
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] valid = '0;
  ioreq_packet_t req [4];
  logic [3:0] ack;
  logic rsp_valid;
  iorsp_packet_t rsp;
  scalar_t slave_data = 32'hCAFE_0000;
  int checks = 0;
  int errors = 0;
  io_bus_interface bus();
  io_bus_arbiter #(.NUM_REQUESTERS(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ioreq_valid(valid),
    .ioreq(req),
    .ioreq_ack(ack),
    .iorsp_valid(rsp_valid),
    .iorsp(rsp),
    .io_bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) bus.read_data <= '0;
    else if (bus.read_en) bus.read_data <= slave_data;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] ack;
    logic re;
    logic we;
    logic rv;
    logic [3:0] core;
    logic [31:0] rval;
  } vec_t;
  vec_t vecs [19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      req[i].store = i[0];
      req[i].thread_idx = i[1:0];
      req[i].address = 32'h100 + 32'(i * 4);
      req[i].value = 32'h5000 + 32'(i);
    end
    vecs[0]  = '{4'hF, 4'b0001, 0, 0, 0, 4'd0, 32'h0};
    vecs[1]  = '{4'hF, 4'b0000, 1, 0, 0, 4'd0, 32'h0};
    vecs[2]  = '{4'hF, 4'b0000, 0, 0, 1, 4'd0, 32'hCAFE_0000};
    vecs[3]  = '{4'hF, 4'b0010, 0, 0, 0, 4'd0, 32'h0};
    vecs[4]  = '{4'hF, 4'b0000, 0, 1, 0, 4'd0, 32'h0};
    vecs[5]  = '{4'hF, 4'b0000, 0, 0, 1, 4'd1, 32'h0};
    vecs[6]  = '{4'hF, 4'b0100, 0, 0, 0, 4'd0, 32'h0};
    vecs[7]  = '{4'hF, 4'b0000, 1, 0, 0, 4'd0, 32'h0};
    vecs[8]  = '{4'hF, 4'b0000, 0, 0, 1, 4'd2, 32'hCAFE_0000};
    vecs[9]  = '{4'hF, 4'b1000, 0, 0, 0, 4'd0, 32'h0};
    vecs[10] = '{4'hF, 4'b0000, 0, 1, 0, 4'd0, 32'h0};
    vecs[11] = '{4'hF, 4'b0000, 0, 0, 1, 4'd3, 32'h0};
    vecs[12] = '{4'b1001, 4'b0001, 0, 0, 0, 4'd0, 32'h0};
    vecs[13] = '{4'b1001, 4'b0000, 1, 0, 0, 4'd0, 32'h0};
    vecs[14] = '{4'b1001, 4'b0000, 0, 0, 1, 4'd0, 32'hCAFE_0000};
    vecs[15] = '{4'b1001, 4'b1000, 0, 0, 0, 4'd0, 32'h0};
    vecs[16] = '{4'b0000, 4'b0000, 0, 1, 0, 4'd0, 32'h0};
    vecs[17] = '{4'b0000, 4'b0000, 0, 0, 1, 4'd3, 32'h0};
    vecs[18] = '{4'b0000, 4'b0000, 0, 0, 0, 4'd0, 32'h0};
    valid = 4'hF;
    #3;
    chk("reset ack", 32'(ack), 0);
    chk("reset read_en", 32'(bus.read_en), 0);
    chk("reset write_en", 32'(bus.write_en), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset address", bus.address, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int v = 0; v < 19; v++) begin
      valid = vecs[v].valid;
      @(negedge clk);
      chk($sformatf("v%0d ack", v), 32'(ack), 32'(vecs[v].ack));
      chk($sformatf("v%0d read_en", v), 32'(bus.read_en), 32'(vecs[v].re));
      chk($sformatf("v%0d write_en", v), 32'(bus.write_en), 32'(vecs[v].we));
      chk($sformatf("v%0d rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].rv));
      if (vecs[v].rv) begin
        chk($sformatf("v%0d core", v), 32'(rsp.core), 32'(vecs[v].core));
        chk($sformatf("v%0d read_value", v), rsp.read_value, vecs[v].rval);
      end
      step();
    end
    req[2] = '{store: 1'b0, thread_idx: 2'd1, address: 32'h0000_0104, value: 32'h0};
    slave_data = 32'hDEAD_BEEF;
    valid = 4'b0100;
    @(negedge clk);
    chk("load ack", 32'(ack), 32'b0100);
    step();
    valid = 4'b0000;
    @(negedge clk);
    chk("load read_en", 32'(bus.read_en), 1);
    chk("load write_en", 32'(bus.write_en), 0);
    chk("load address", bus.address, 32'h104);
    step();
    @(negedge clk);
    chk("load rsp_valid", 32'(rsp_valid), 1);
    chk("load core", 32'(rsp.core), 2);
    chk("load thread", 32'(rsp.thread_idx), 1);
    chk("load value", rsp.read_value, 32'hDEAD_BEEF);
    step();
    req[0] = '{store: 1'b1, thread_idx: 2'd0, address: 32'h80, value: 32'h1234_5678};
    valid = 4'b0001;
    @(negedge clk);
    chk("store ack", 32'(ack), 32'b0001);
    step();
    valid = 4'b0000;
    @(negedge clk);
    chk("store write_en", 32'(bus.write_en), 1);
    chk("store read_en", 32'(bus.read_en), 0);
    chk("store write_data", bus.write_data, 32'h1234_5678);
    chk("store address", bus.address, 32'h80);
    step();
    @(negedge clk);
    chk("store write_en drop", 32'(bus.write_en), 0);
    chk("store rsp_valid", 32'(rsp_valid), 1);
    chk("store core", 32'(rsp.core), 0);
    chk("store value", rsp.read_value, 32'h0);
    step();
    valid = 4'b0001;
    @(negedge clk);
    chk("wd ack0", 32'(ack), 32'b0001);
    step();
    valid = 4'b0010;
    @(negedge clk);
    chk("wd bus ack", 32'(ack), 0);
    step();
    valid = 4'b0000;
    @(negedge clk);
    chk("wd resp ack", 32'(ack), 0);
    chk("wd resp core", 32'(rsp.core), 0);
    step();
    @(negedge clk);
    chk("wd idle ack", 32'(ack), 0);
    chk("wd idle strobes", 32'({bus.read_en, bus.write_en}), 0);
    chk("wd idle rsp_valid", 32'(rsp_valid), 0);
    step();
    @(negedge clk);
    chk("wd no late rsp", 32'(rsp_valid), 0);
    step();
    req[1].store = 1'b0;
    valid = 4'b0010;
    @(negedge clk);
    chk("rst pre ack", 32'(ack), 32'b0010);
    step();
    chk("rst pre read_en", 32'(bus.read_en), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst async read_en", 32'(bus.read_en), 0);
    chk("rst async write_en", 32'(bus.write_en), 0);
    chk("rst async ack", 32'(ack), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst hold rsp_valid %0d", c), 32'(rsp_valid), 0);
    end
    step();
    valid = 4'b1010;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post rst ack", 32'(ack), 32'b0010);
    step();
    valid = 4'b0000;
    @(negedge clk);
    chk("post rst read_en", 32'(bus.read_en), 1);
    step();
    @(negedge clk);
    chk("post rst rsp_valid", 32'(rsp_valid), 1);
    chk("post rst core", 32'(rsp.core), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
